itlb_refill_ctrl: RTL and testbench

//  Write-side controller for the per-thread ITLB RAM: accepts one ITLB miss at a time from the IU,

---
 rtl/itlb_refill_ctrl_pkg.sv | 33 +++
 rtl/itlb_refill_ctrl_if.sv | 23 ++
 rtl/itlb_ecc_scrub.sv | 66 ++++++
 rtl/itlb_refill_ctrl.sv | 144 ++++++++++++++
 tb/tb_itlb_refill_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/itlb_refill_ctrl_pkg.sv
// Shared types and constants for the ITLB refill controller: RAM address/data formats,
// refill FSM states and the clock bundle delivered by the IU.
package itlb_refill_ctrl_pkg;

  localparam int ITLB_TID_W  = 6;
  localparam int ITLB_IDX_W  = 3;
  localparam int ITLB_ADDR_W = ITLB_TID_W + ITLB_IDX_W;
  localparam int ITLB_DATA_W = 64;

  typedef logic [ITLB_ADDR_W-1:0] mmu_itlbram_addr_type;
  typedef logic [ITLB_DATA_W-1:0] mmu_itlbram_data_type;

  typedef struct packed {
    logic clk;
    logic ce;
    logic clk2x;
  } iu_clk_type;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    WR
  } itlb_refill_state_type;

  // An all-zero entry has its valid bit clear, so writing it forces a refill on next use.
  localparam mmu_itlbram_data_type ITLB_INVALID_ENTRY = '0;

  function automatic logic [ITLB_TID_W-1:0] itlb_addr_tid(input mmu_itlbram_addr_type addr);
    return addr[ITLB_ADDR_W-1 -: ITLB_TID_W];
  endfunction

endpackage

// File: rtl/itlb_refill_ctrl_if.sv
// Fill-request/response handshake between the refill controller (master) and the
// page-table walker (slave).
interface itlb_refill_ctrl_if;
  import itlb_refill_ctrl_pkg::*;

  logic                 req_valid;
  mmu_itlbram_addr_type req_addr;
  logic                 req_ready;
  logic                 resp_valid;
  mmu_itlbram_data_type resp_data;
  logic                 resp_err;

  modport master (
    output req_valid, req_addr,
    input  req_ready, resp_valid, resp_data, resp_err
  );

  modport slave (
    input  req_valid, req_addr,
    output req_ready, resp_valid, resp_data, resp_err
  );

endinterface

// File: rtl/itlb_ecc_scrub.sv
// ECC flag consumer: holds one pending scrub address, requests a RAM write slot for it
// and keeps saturating single/double-bit error counts.
module itlb_ecc_scrub
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 sberr_i,
  input  logic                 dberr_i,
  input  mmu_itlbram_addr_type chk_addr_i,
  input  logic                 scrub_gnt_i,
  output logic                 scrub_req_o,
  output mmu_itlbram_addr_type scrub_addr_o,
  output logic [ERRCNT_W-1:0]  sberr_cnt_o,
  output logic [ERRCNT_W-1:0]  dberr_cnt_o
);

  logic                 pend_q, pend_d;
  mmu_itlbram_addr_type addr_q, addr_d;
  logic [ERRCNT_W-1:0]  sb_cnt_q, sb_cnt_d;
  logic [ERRCNT_W-1:0]  db_cnt_q, db_cnt_d;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pend_q   <= 1'b0;
      addr_q   <= '0;
      sb_cnt_q <= '0;
      db_cnt_q <= '0;
    end else begin
      pend_q   <= pend_d;
      addr_q   <= addr_d;
      sb_cnt_q <= sb_cnt_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    pend_d   = pend_q;
    addr_d   = addr_q;
    sb_cnt_d = sb_cnt_q;
    db_cnt_d = db_cnt_q;

    if (pend_q && scrub_gnt_i) pend_d = 1'b0;
    // Only one scrub can be outstanding; later flags are counted but their address is dropped.
    if (!pend_q && (sberr_i || dberr_i)) begin
      pend_d = 1'b1;
      addr_d = chk_addr_i;
    end

    if (dberr_i) begin
      if (!(&db_cnt_q)) db_cnt_d = db_cnt_q + ERRCNT_W'(1);
    end else if (sberr_i) begin
      if (!(&sb_cnt_q)) sb_cnt_d = sb_cnt_q + ERRCNT_W'(1);
    end
  end

  assign scrub_req_o  = pend_q;
  assign scrub_addr_o = addr_q;
  assign sberr_cnt_o  = sb_cnt_q;
  assign dberr_cnt_o  = db_cnt_q;

endmodule

// File: rtl/itlb_refill_ctrl.sv
// ITLB RAM write-side controller: refills one missing entry at a time through the walker
// and invalidates entries flagged by the RAM's ECC check.
module itlb_refill_ctrl
  import itlb_refill_ctrl_pkg::*;
#(
  parameter int ERRCNT_W = 16
) (
  input  iu_clk_type               gclk_i,
  input  logic                     rst_i,
  input  logic                     miss_valid_i,
  input  mmu_itlbram_addr_type     miss_addr_i,
  output logic                     miss_ready_o,
  itlb_refill_ctrl_if.master       mem,
  input  mmu_itlbram_addr_type     chk_addr_i,
  input  logic                     sberr_i,
  input  logic                     dberr_i,
  output mmu_itlbram_addr_type     waddr_o,
  output logic                     we_o,
  output mmu_itlbram_data_type     wdata_o,
  output logic                     done_valid_o,
  output logic [ITLB_TID_W-1:0]    done_tid_o,
  output logic                     done_fault_o,
  output logic [ERRCNT_W-1:0]      sberr_cnt_o,
  output logic [ERRCNT_W-1:0]      dberr_cnt_o
);

  logic                  clk;
  logic                  unused_clk_aux;
  itlb_refill_state_type state_q, state_d;
  mmu_itlbram_addr_type  addr_q, addr_d;
  mmu_itlbram_data_type  data_q, data_d;
  logic                  err_q, err_d;
  logic                  req_valid;
  mmu_itlbram_addr_type  req_addr;
  logic                  scrub_req, scrub_gnt;
  mmu_itlbram_addr_type  scrub_addr;

  assign clk            = gclk_i.clk;
  assign unused_clk_aux = gclk_i.ce ^ gclk_i.clk2x;
  assign mem.req_valid  = req_valid;
  assign mem.req_addr   = req_addr;

  itlb_ecc_scrub #(.ERRCNT_W(ERRCNT_W)) u_scrub (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .sberr_i      (sberr_i),
    .dberr_i      (dberr_i),
    .chk_addr_i   (chk_addr_i),
    .scrub_gnt_i  (scrub_gnt),
    .scrub_req_o  (scrub_req),
    .scrub_addr_o (scrub_addr),
    .sberr_cnt_o  (sberr_cnt_o),
    .dberr_cnt_o  (dberr_cnt_o)
  );

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    err_d        = err_q;
    miss_ready_o = 1'b0;
    req_valid    = 1'b0;
    req_addr     = '0;
    we_o         = 1'b0;
    waddr_o      = '0;
    wdata_o      = '0;
    done_valid_o = 1'b0;
    done_tid_o   = '0;
    done_fault_o = 1'b0;
    scrub_gnt    = 1'b0;

    // A pending scrub always owns the write port; the fill write waits behind it.
    if (scrub_req) begin
      we_o      = 1'b1;
      waddr_o   = scrub_addr;
      wdata_o   = ITLB_INVALID_ENTRY;
      scrub_gnt = 1'b1;
    end

    case (state_q)
      IDLE: begin
        miss_ready_o = 1'b1;
        if (miss_valid_i) begin
          addr_d  = miss_addr_i;
          state_d = REQ;
        end
      end
      REQ: begin
        req_valid = 1'b1;
        req_addr  = addr_q;
        if (mem.req_ready) state_d = WAIT;
      end
      WAIT: begin
        if (mem.resp_valid) begin
          data_d  = mem.resp_data;
          err_d   = mem.resp_err;
          state_d = WR;
        end
      end
      WR: begin
        if (!scrub_req) begin
          if (!err_q) begin
            we_o    = 1'b1;
            waddr_o = addr_q;
            wdata_o = data_q;
          end
          done_valid_o = 1'b1;
          done_tid_o   = itlb_addr_tid(addr_q);
          done_fault_o = err_q;
          state_d      = IDLE;
        end
      end
    endcase

    // Reset is synchronous, so the registers may still hold a mid-fill state this cycle.
    if (rst_i) begin
      miss_ready_o = 1'b0;
      req_valid    = 1'b0;
      req_addr     = '0;
      we_o         = 1'b0;
      waddr_o      = '0;
      wdata_o      = '0;
      done_valid_o = 1'b0;
      done_tid_o   = '0;
      done_fault_o = 1'b0;
      scrub_gnt    = 1'b0;
    end
  end

endmodule

// File: tb/tb_itlb_refill_ctrl.sv
// Self-checking bench for itlb_refill_ctrl: directed cases followed by randomized fills
// and ECC flags, compared against a transaction-level model of the write port.
module tb_itlb_refill_ctrl;
  import itlb_refill_ctrl_pkg::*;

  localparam int            CW      = 4;
  localparam logic [CW-1:0] CNT_MAX = '1;

  logic                 clk;
  iu_clk_type           gclk;
  logic                 rst_i;
  logic                 miss_valid, miss_ready;
  mmu_itlbram_addr_type miss_addr, chk_addr, waddr;
  logic                 sberr, dberr, we;
  mmu_itlbram_data_type wdata;
  logic                 done_valid, done_fault;
  logic [5:0]           done_tid;
  logic [CW-1:0]        sberr_cnt, dberr_cnt;

  itlb_refill_ctrl_if mem_if ();

  assign gclk = {clk, 1'b1, 1'b0};

  itlb_refill_ctrl #(.ERRCNT_W(CW)) dut (
    .gclk_i       (gclk),
    .rst_i        (rst_i),
    .miss_valid_i (miss_valid),
    .miss_addr_i  (miss_addr),
    .miss_ready_o (miss_ready),
    .mem          (mem_if),
    .chk_addr_i   (chk_addr),
    .sberr_i      (sberr),
    .dberr_i      (dberr),
    .waddr_o      (waddr),
    .we_o         (we),
    .wdata_o      (wdata),
    .done_valid_o (done_valid),
    .done_tid_o   (done_tid),
    .done_fault_o (done_fault),
    .sberr_cnt_o  (sberr_cnt),
    .dberr_cnt_o  (dberr_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int n_checks;
  int n_errors;
  bit rand_flags;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Expected RAM traffic: scrub writes land exactly one cycle after the flag is seen,
  // fill writes coincide with their done pulse and follow the order of the responses.
  typedef struct { mmu_itlbram_addr_type addr; int due; } scrub_t;
  typedef struct { mmu_itlbram_addr_type addr; mmu_itlbram_data_type data; logic fault; } fill_t;

  scrub_t scrub_q[$];
  fill_t  fill_q[$];
  int     cyc;
  bit     prev_acc;
  int     sb_model, db_model;

  function automatic int sat_inc(input int v);
    return (v >= int'(CNT_MAX)) ? int'(CNT_MAX) : v + 1;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst_i) begin
      sb_model = 0;
      db_model = 0;
      prev_acc = 1'b0;
    end else begin
      if (dberr)      db_model = sat_inc(db_model);
      else if (sberr) sb_model = sat_inc(sb_model);
      if ((sberr || dberr) && !prev_acc) begin
        scrub_q.push_back(scrub_t'{chk_addr, cyc});
        prev_acc = 1'b1;
      end else begin
        prev_acc = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    scrub_t s;
    fill_t  f;
    if (rst_i) begin
      check("we_in_reset", we, 1'b0);
      check("done_in_reset", done_valid, 1'b0);
      while (scrub_q.size() > 0 && scrub_q[0].due <= cyc) void'(scrub_q.pop_front());
    end else begin
      check("sberr_cnt", sberr_cnt, sb_model);
      check("dberr_cnt", dberr_cnt, db_model);
      if (scrub_q.size() > 0 && scrub_q[0].due == cyc) begin
        s = scrub_q.pop_front();
        check("scrub_we", we, 1'b1);
        check("scrub_waddr", waddr, s.addr);
        check("scrub_wdata", wdata, ITLB_INVALID_ENTRY);
        check("scrub_holds_done", done_valid, 1'b0);
      end else if (done_valid) begin
        check("done_expected", fill_q.size() > 0, 1'b1);
        if (fill_q.size() > 0) begin
          f = fill_q.pop_front();
          check("done_tid", done_tid, f.addr[8:3]);
          check("done_fault", done_fault, f.fault);
          check("fill_we", we, !f.fault);
          if (!f.fault) begin
            check("fill_waddr", waddr, f.addr);
            check("fill_wdata", wdata, f.data);
          end
        end
      end else begin
        check("no_stray_write", we, 1'b0);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_flags) begin
      sberr    = ($urandom_range(0, 5) == 0);
      dberr    = ($urandom_range(0, 9) == 0);
      chk_addr = mmu_itlbram_addr_type'($urandom);
    end
  endtask

  function automatic mmu_itlbram_data_type rand_data();
    return {$urandom, $urandom} | 64'h1;
  endfunction

  task automatic do_fill(input logic [5:0] tid, input logic [2:0] idx, input int req_dly,
                         input int resp_dly, input logic err, input mmu_itlbram_data_type data,
                         input bit stray, input bit sb_with_resp);
    mmu_itlbram_addr_type a;
    int n;
    a = {tid, idx};
    miss_valid = 1'b1;
    miss_addr  = a;
    #1;
    check("miss_ready_idle", miss_ready, 1'b1);
    tick();
    miss_valid = 1'b0;
    miss_addr  = mmu_itlbram_addr_type'($urandom);
    for (int i = 0; i < req_dly; i++) begin
      if (stray && i == 0) begin
        mem_if.resp_valid = 1'b1;
        mem_if.resp_data  = rand_data();
      end
      #1;
      check("req_valid_hold", mem_if.req_valid, 1'b1);
      check("req_addr_hold", mem_if.req_addr, a);
      check("miss_ready_busy", miss_ready, 1'b0);
      tick();
      mem_if.resp_valid = 1'b0;
    end
    mem_if.req_ready = 1'b1;
    #1;
    check("req_valid", mem_if.req_valid, 1'b1);
    check("req_addr", mem_if.req_addr, a);
    tick();
    mem_if.req_ready = 1'b0;
    for (int i = 0; i < resp_dly; i++) begin
      #1;
      check("req_drop_in_wait", mem_if.req_valid, 1'b0);
      check("miss_ready_wait", miss_ready, 1'b0);
      tick();
    end
    mem_if.resp_valid = 1'b1;
    mem_if.resp_data  = data;
    mem_if.resp_err   = err;
    if (sb_with_resp) begin
      sberr    = 1'b1;
      chk_addr = 9'h1FF;
    end
    fill_q.push_back(fill_t'{a, data, err});
    tick();
    mem_if.resp_valid = 1'b0;
    mem_if.resp_err   = 1'b0;
    mem_if.resp_data  = rand_data();
    if (sb_with_resp) begin
      sberr = 1'b0;
      #1;
      check("scrub_first_we", we, 1'b1);
      check("scrub_first_waddr", waddr, 9'h1FF);
      check("scrub_first_wdata", wdata, ITLB_INVALID_ENTRY);
      check("scrub_first_no_done", done_valid, 1'b0);
      tick();
      #1;
      check("fill_next_we", we, 1'b1);
      check("fill_next_waddr", waddr, a);
      check("fill_next_wdata", wdata, data);
      check("fill_next_done", done_valid, 1'b1);
    end else if (!rand_flags) begin
      #1;
      check("wr_done", done_valid, 1'b1);
      check("wr_done_tid", done_tid, tid);
      check("wr_done_fault", done_fault, err);
      check("wr_we", we, !err);
      check("miss_ready_wr", miss_ready, 1'b0);
    end
    n = 0;
    while (miss_ready !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check("return_to_idle", miss_ready, 1'b1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rand_flags = 1'b0;
    rst_i      = 1'b1;
    miss_valid = 1'b0;
    miss_addr  = '0;
    chk_addr   = '0;
    sberr      = 1'b0;
    dberr      = 1'b0;
    mem_if.req_ready  = 1'b0;
    mem_if.resp_valid = 1'b0;
    mem_if.resp_data  = '0;
    mem_if.resp_err   = 1'b0;

    // Reset state
    repeat (3) tick();
    check("rst_we", we, 1'b0);
    check("rst_waddr", waddr, '0);
    check("rst_wdata", wdata, '0);
    check("rst_req_valid", mem_if.req_valid, 1'b0);
    check("rst_req_addr", mem_if.req_addr, '0);
    check("rst_done", done_valid, 1'b0);
    rst_i = 1'b0;
    #1;
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_sberr_cnt", sberr_cnt, '0);
    check("rst_dberr_cnt", dberr_cnt, '0);
    tick();

    // Basic fill tid=5 idx=3, request accepted at once, response two cycles later
    do_fill(6'd5, 3'd3, 0, 2, 1'b0, 64'hDEAD_BEEF_0123_4567, 1'b0, 1'b0);
    tick();

    // Walker stalls the request for 10 cycles; stray response during REQ is ignored
    do_fill(6'd17, 3'd6, 10, 1, 1'b0, rand_data(), 1'b1, 1'b0);
    tick();

    // Walk fault: no RAM write, done with fault
    do_fill(6'd42, 3'd0, 1, 0, 1'b1, rand_data(), 1'b0, 1'b0);
    tick();

    // sberr on chk_addr 1FF arriving with the response: scrub write precedes the fill write
    do_fill(6'd2, 3'd6, 0, 1, 1'b0, rand_data(), 1'b0, 1'b1);
    #1;
    check("sb_after_scrub", sberr_cnt, 4'd1);
    tick();

    // Two back-to-back dberr: one scrub to the first address, both counted
    dberr    = 1'b1;
    chk_addr = 9'h011;
    tick();
    chk_addr = 9'h022;
    #1;
    check("dd_scrub_we", we, 1'b1);
    check("dd_scrub_waddr", waddr, 9'h011);
    tick();
    dberr = 1'b0;
    #1;
    check("dd_second_dropped", we, 1'b0);
    check("dd_count", dberr_cnt, 4'd2);
    tick();
    // sberr together with dberr counts as double-bit only
    sberr    = 1'b1;
    dberr    = 1'b1;
    chk_addr = 9'h033;
    tick();
    sberr = 1'b0;
    dberr = 1'b0;
    #1;
    check("both_sb_cnt", sberr_cnt, 4'd1);
    check("both_db_cnt", dberr_cnt, 4'd3);
    check("both_scrub_waddr", waddr, 9'h033);
    tick();
    // Drive the double-bit counter to all-ones and beyond
    dberr = 1'b1;
    repeat (12) tick();
    dberr = 1'b0;
    #1;
    check("db_at_max", dberr_cnt, CNT_MAX);
    tick();
    dberr = 1'b1;
    repeat (3) tick();
    dberr = 1'b0;
    #1;
    check("db_saturated", dberr_cnt, CNT_MAX);
    repeat (3) tick();

    // Reset while waiting for the walker; response after reset is ignored
    miss_valid = 1'b1;
    miss_addr  = {6'd9, 3'd1};
    tick();
    miss_valid       = 1'b0;
    mem_if.req_ready = 1'b1;
    tick();
    mem_if.req_ready = 1'b0;
    tick();
    rst_i = 1'b1;
    #1;
    check("midrst_we", we, 1'b0);
    check("midrst_done", done_valid, 1'b0);
    tick();
    rst_i = 1'b0;
    mem_if.resp_valid = 1'b1;
    mem_if.resp_data  = rand_data();
    #1;
    check("midrst_miss_ready", miss_ready, 1'b1);
    check("midrst_req_valid", mem_if.req_valid, 1'b0);
    check("midrst_sb_clear", sberr_cnt, '0);
    check("midrst_db_clear", dberr_cnt, '0);
    tick();
    mem_if.resp_valid = 1'b0;
    #1;
    check("midrst_no_we", we, 1'b0);
    check("midrst_no_done", done_valid, 1'b0);
    repeat (2) tick();

    // Randomized fills with background ECC flags
    rand_flags = 1'b1;
    for (int t = 0; t < 40; t++) begin
      do_fill(6'($urandom), 3'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 4) == 0), rand_data(), 1'($urandom), 1'b0);
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_flags = 1'b0;
    sberr      = 1'b0;
    dberr      = 1'b0;
    repeat (4) tick();

    check("fills_drained", fill_q.size(), 0);
    check("scrubs_drained", scrub_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
